lut_search: RTL and testbench

LUT_SEARCH -- requirements
Module: lut_search

---
 rtl/lut_search.sv | 183 ++++++++++++++++++
 tb/tb_lut_search.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_search.sv
// Period-count to switching-state lookup: sequential binary search over a descending
// corner table, optional coarse grid mapping and a consecutive-result confirm filter.
module lut_search #(
  parameter int unsigned NCLK_W        = 14,
  parameter int unsigned NUM_CORNERS   = 80,
  parameter int unsigned STATE_W       = 7,
  parameter int unsigned COARSE_OFFSET = 4,
  parameter int unsigned COARSE_SHIFT  = 3,
  parameter int unsigned CONFIRM       = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_CORNERS)-1:0] wr_addr,
  input  logic [NCLK_W-1:0]              wr_data,
  input  logic                           n_valid,
  input  logic [NCLK_W-1:0]              n_clk,
  input  logic                           coarse_en,
  output logic                           ready,
  output logic [STATE_W-1:0]             state,
  output logic                           state_valid,
  output logic                           state_changed
);

  localparam int unsigned ADDR_W   = $clog2(NUM_CORNERS);
  localparam int unsigned IDX_W    = $clog2(NUM_CORNERS + 1);
  localparam int unsigned NUM_ITER = IDX_W;
  localparam int unsigned ITER_W   = $clog2(NUM_ITER + 1);

  localparam logic [ADDR_W:0]    NUM_A     = (ADDR_W + 1)'(NUM_CORNERS);
  localparam logic [IDX_W-1:0]   NUM_I     = IDX_W'(NUM_CORNERS);
  localparam logic [STATE_W-1:0] NUM_S     = STATE_W'(NUM_CORNERS);
  localparam logic [STATE_W-1:0] OFF_S     = STATE_W'(COARSE_OFFSET);
  localparam logic [STATE_W-1:0] GRID_MASK = ~STATE_W'((1 << COARSE_SHIFT) - 1);
  localparam logic [3:0]         CONFIRM_C = 4'(CONFIRM);
  localparam logic [ITER_W-1:0]  LAST_ITER = ITER_W'(NUM_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_RESULT = 2'd2
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [NCLK_W-1:0]  n_q, n_d;
  logic               coarse_q, coarse_d;
  logic [IDX_W-1:0]   lo_q, lo_d;
  logic [IDX_W-1:0]   hi_q, hi_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [STATE_W-1:0] cand_q, cand_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               valid_q, valid_d;
  logic               changed_q, changed_d;
  logic               ready_q, ready_d;

  logic [NCLK_W-1:0]  corner_q [NUM_CORNERS];

  logic               wr_ok;
  logic [IDX_W-1:0]   mid;
  logic               mid_ok;
  logic [NCLK_W-1:0]  rd_data;
  logic               hit;
  logic [STATE_W-1:0] fine;
  logic [STATE_W-1:0] coarse_val;
  logic [STATE_W-1:0] mapped;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < NUM_A);

  // Corner table; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corner_q <= '{default: '0};
    end else if (wr_ok) begin
      corner_q[wr_addr] <= wr_data;
    end
  end

  // Probe point of the search; mid only reaches NUM_CORNERS once the interval has collapsed.
  assign mid     = IDX_W'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
  assign mid_ok  = (mid < NUM_I);
  assign rd_data = mid_ok ? corner_q[ADDR_W'(mid)] : '0;
  assign hit     = !mid_ok || (n_q > rd_data);

  assign fine       = NUM_S - STATE_W'(lo_q);
  assign coarse_val = (fine < OFF_S) ? OFF_S : (((fine - OFF_S) & GRID_MASK) + OFF_S);
  assign mapped     = coarse_q ? coarse_val : fine;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= S_IDLE;
      n_q       <= '0;
      coarse_q  <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      iter_q    <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      state_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      fsm_q     <= fsm_d;
      n_q       <= n_d;
      coarse_q  <= coarse_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      iter_q    <= iter_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    n_d       = n_q;
    coarse_d  = coarse_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    iter_d    = iter_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;

    case (fsm_q)
      S_IDLE: begin
        if (n_valid) begin
          n_d      = n_clk;
          coarse_d = coarse_en;
          lo_d     = '0;
          hi_d     = NUM_I;
          iter_d   = '0;
          fsm_d    = S_SEARCH;
        end
      end
      S_SEARCH: begin
        // A table write invalidates the partial search; rerun on the latched sample.
        if (wr_ok) begin
          lo_d   = '0;
          hi_d   = NUM_I;
          iter_d = '0;
        end else begin
          if (lo_q < hi_q) begin
            if (hit) hi_d = mid;
            else     lo_d = mid + 1'b1;
          end
          iter_d = iter_q + 1'b1;
          if (iter_q == LAST_ITER) fsm_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (mapped == cand_q) begin
          cnt_d = (cnt_q >= CONFIRM_C) ? CONFIRM_C : cnt_q + 4'd1;
        end else begin
          cand_d = mapped;
          cnt_d  = 4'd1;
        end
        if ((cnt_d == CONFIRM_C) && (cand_d != state_q)) begin
          state_d   = cand_d;
          changed_d = 1'b1;
        end
        valid_d = 1'b1;
        fsm_d   = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase

    ready_d = (fsm_d == S_IDLE);
  end

  assign ready         = ready_q;
  assign state         = state_q;
  assign state_valid   = valid_q;
  assign state_changed = changed_q;

endmodule

// File: tb/tb_lut_search.sv
// Self-checking bench for lut_search: directed corner cases plus randomized lookups
// against a linear-scan reference model; a second instance runs with CONFIRM=2.
module tb_lut_search;
  localparam int NC = 80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [13:0] wr_data;
  logic        n_valid;
  logic [13:0] n_clk;
  logic        coarse_en;
  logic        ready1, valid1, chg1;
  logic [6:0]  state1;
  logic        ready2, valid2, chg2;
  logic [6:0]  state2;

  int n_checks = 0;
  int n_errors = 0;

  int tbl [NC];
  int m_state1, m2_cand, m2_cnt, m2_state;

  int obs_lat;
  int obs_ready_bad;
  bit obs_valid2;

  always #5 clk = ~clk;

  lut_search u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .n_valid(n_valid), .n_clk(n_clk), .coarse_en(coarse_en),
    .ready(ready1), .state(state1), .state_valid(valid1), .state_changed(chg1)
  );

  lut_search #(.CONFIRM(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .n_valid(n_valid), .n_clk(n_clk), .coarse_en(coarse_en),
    .ready(ready2), .state(state2), .state_valid(valid2), .state_changed(chg2)
  );

  // Reference: linear scan for the first corner strictly below n, then optional grid snap.
  function automatic int ref_map(input int n, input bit ce);
    int fine;
    fine = 0;
    for (int i = 0; i < NC; i++) begin
      if (n > tbl[i]) begin
        fine = NC - i;
        break;
      end
    end
    if (ce) begin
      if (fine < 4) fine = 4;
      else          fine = ((fine - 4) / 8) * 8 + 4;
    end
    return fine;
  endfunction

  task automatic model_step(input int mapped, output bit c1, output bit c2);
    c1 = (mapped != m_state1);
    m_state1 = mapped;
    if (mapped == m2_cand) begin
      if (m2_cnt < 2) m2_cnt++;
    end else begin
      m2_cand = mapped;
      m2_cnt  = 1;
    end
    c2 = 1'b0;
    if (m2_cnt == 2 && m2_cand != m2_state) begin
      m2_state = m2_cand;
      c2 = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; n_valid = 1'b0; wr_en = 1'b0; coarse_en = 1'b0;
    n_clk = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    m_state1 = 0; m2_cand = 0; m2_cnt = 0; m2_state = 0;
    for (int i = 0; i < NC; i++) tbl[i] = 0;
  endtask

  task automatic write_entry(input int wa, input int wd);
    wr_en = 1'b1; wr_addr = 7'(wa); wr_data = 14'(wd);
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (wa < NC) tbl[wa] = wd;
  endtask

  task automatic load_table();
    for (int i = 0; i < NC; i++) write_entry(i, 8000 - 50 * i);
  endtask

  // Offer one sample; optionally write the table at edge wr_at after accept, or hold n_valid busy.
  task automatic lookup(input int n, input bit ce, input int wr_at, input int wa, input int wd,
                        input bit hold);
    obs_lat = 0; obs_ready_bad = 0; obs_valid2 = 1'b0;
    n_valid = 1'b1; n_clk = 14'(n); coarse_en = ce;
    @(posedge clk); #1;
    if (hold) n_clk = 14'($urandom_range(0, 16383));
    else      n_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = 7'(wa); wr_data = 14'(wd);
        tbl[wa] = wd;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (valid1) begin
        obs_lat = k;
        obs_valid2 = valid2;
        if (!ready1) obs_ready_bad++;
        break;
      end
      if (ready1) obs_ready_bad++;
    end
    n_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (ready1 !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%0b exp=1", ready1); end
    n_checks++; if (state1 !== 7'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state1); end
    n_checks++; if (valid1 !== 1'b0 || chg1 !== 1'b0) begin n_errors++; $display("FAIL reset_pulses got=%0b%0b exp=00", valid1, chg1); end
    n_checks++; if (ready2 !== 1'b1 || state2 !== 7'd0) begin n_errors++; $display("FAIL reset_dut2 got ready=%0b state=%0d exp 1/0", ready2, state2); end
  endtask

  task automatic test_fine();
    int vn [5] = '{8001, 8000, 4051, 4050, 0};
    int vs [5] = '{80, 79, 1, 0, 0};
    bit c1, c2;
    load_table();
    for (int t = 0; t < 5; t++) begin
      lookup(vn[t], 1'b0, 0, 0, 0, 1'b0);
      model_step(vs[t], c1, c2);
      n_checks++; if (obs_lat !== 8) begin n_errors++; $display("FAIL fine_latency n=%0d got=%0d exp=8", vn[t], obs_lat); end
      n_checks++; if (state1 !== 7'(vs[t])) begin n_errors++; $display("FAIL fine_state n=%0d got=%0d exp=%0d", vn[t], state1, vs[t]); end
      n_checks++; if (chg1 !== c1) begin n_errors++; $display("FAIL fine_changed n=%0d got=%0b exp=%0b", vn[t], chg1, c1); end
      n_checks++; if (obs_ready_bad !== 0) begin n_errors++; $display("FAIL fine_ready n=%0d bad_cycles=%0d exp=0", vn[t], obs_ready_bad); end
    end
  endtask

  task automatic test_coarse();
    int vn [4] = '{8000, 4120, 4620, 0};
    int vs [4] = '{76, 4, 12, 4};
    bit c1, c2;
    for (int t = 0; t < 4; t++) begin
      lookup(vn[t], 1'b1, 0, 0, 0, 1'b0);
      model_step(vs[t], c1, c2);
      n_checks++; if (state1 !== 7'(vs[t]) || obs_lat !== 8) begin n_errors++; $display("FAIL coarse n=%0d got=%0d lat=%0d exp=%0d lat=8", vn[t], state1, obs_lat, vs[t]); end
    end
  endtask

  task automatic test_write_restart();
    bit c1, c2;
    lookup(7760, 1'b0, 4, 5, 7770, 1'b0);
    model_step(74, c1, c2);
    n_checks++; if (obs_lat !== 12) begin n_errors++; $display("FAIL restart_latency got=%0d exp=12", obs_lat); end
    n_checks++; if (state1 !== 7'd74) begin n_errors++; $display("FAIL restart_state got=%0d exp=74", state1); end
    n_checks++; if (obs_ready_bad !== 0) begin n_errors++; $display("FAIL restart_ready bad_cycles=%0d exp=0", obs_ready_bad); end
    write_entry(5, 7750);
  endtask

  task automatic test_busy_ignore();
    bit c1, c2;
    lookup(6020, 1'b0, 0, 0, 0, 1'b1);
    model_step(40, c1, c2);
    n_checks++; if (state1 !== 7'd40 || obs_lat !== 8) begin n_errors++; $display("FAIL busy_ignore got=%0d lat=%0d exp=40 lat=8", state1, obs_lat); end
    @(posedge clk); #1;
    n_checks++; if (ready1 !== 1'b1 || valid1 !== 1'b0) begin n_errors++; $display("FAIL busy_no_queue got ready=%0b valid=%0b exp 1/0", ready1, valid1); end
  endtask

  task automatic test_random();
    bit c1, c2;
    int n, exp, wr_at, wa, wd;
    bit ce;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) write_entry(int'($urandom_range(80, 127)), int'($urandom_range(0, 16383)));
      n = int'($urandom_range(0, 8100));
      ce = 1'($urandom_range(0, 1));
      wr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      wa = int'($urandom_range(0, NC - 1));
      wd = 8000 - 50 * wa + int'($urandom_range(0, 40)) - 20;
      lookup(n, ce, wr_at, wa, wd, 1'b0);
      exp = ref_map(n, ce);
      model_step(exp, c1, c2);
      n_checks++; if (obs_lat !== 8 + wr_at) begin n_errors++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, obs_lat, 8 + wr_at); end
      n_checks++; if (state1 !== 7'(exp) || chg1 !== c1) begin n_errors++; $display("FAIL rand_state n=%0d ce=%0b got=%0d/%0b exp=%0d/%0b", n, ce, state1, chg1, exp, c1); end
      n_checks++; if (state2 !== 7'(m2_state) || chg2 !== c2 || obs_valid2 !== 1'b1) begin n_errors++; $display("FAIL rand_confirm2 n=%0d got=%0d/%0b exp=%0d/%0b", n, state2, chg2, m2_state, c2); end
    end
  endtask

  task automatic test_confirm();
    int vn [4] = '{6020, 6070, 6070, 6070};
    int e2 [4] = '{0, 0, 41, 41};
    bit x2 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit c1, c2;
    apply_reset();
    load_table();
    for (int t = 0; t < 4; t++) begin
      lookup(vn[t], 1'b0, 0, 0, 0, 1'b0);
      model_step(ref_map(vn[t], 1'b0), c1, c2);
      n_checks++; if (state2 !== 7'(e2[t]) || chg2 !== x2[t] || obs_valid2 !== 1'b1) begin n_errors++; $display("FAIL confirm2 step=%0d got=%0d/%0b/%0b exp=%0d/%0b/1", t, state2, chg2, obs_valid2, e2[t], x2[t]); end
      n_checks++; if (state1 !== 7'(m_state1) || chg1 !== c1) begin n_errors++; $display("FAIL confirm1 step=%0d got=%0d/%0b exp=%0d/%0b", t, state1, chg1, m_state1, c1); end
    end
  endtask

  task automatic test_reset_mid();
    int saw_valid;
    bit c1, c2;
    n_valid = 1'b1; n_clk = 14'd5000; coarse_en = 1'b0;
    @(posedge clk); #1;
    n_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (state1 !== 7'd0 || valid1 !== 1'b0 || state2 !== 7'd0) begin n_errors++; $display("FAIL midreset_state got=%0d/%0d valid=%0b exp 0/0/0", state1, state2, valid1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_state1 = 0; m2_cand = 0; m2_cnt = 0; m2_state = 0;
    for (int i = 0; i < NC; i++) tbl[i] = 0;
    saw_valid = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (valid1 || valid2) saw_valid++;
    end
    n_checks++; if (saw_valid !== 0 || ready1 !== 1'b1) begin n_errors++; $display("FAIL midreset_abort valid_pulses=%0d ready=%0b exp 0/1", saw_valid, ready1); end
    lookup(1, 1'b0, 0, 0, 0, 1'b0);
    model_step(80, c1, c2);
    n_checks++; if (state1 !== 7'd80 || chg1 !== 1'b1 || obs_lat !== 8) begin n_errors++; $display("FAIL midreset_cleared got=%0d/%0b lat=%0d exp=80/1 lat=8", state1, chg1, obs_lat); end
  endtask

  initial begin
    test_reset();
    test_fine();
    test_coarse();
    test_write_restart();
    test_busy_ignore();
    test_random();
    test_confirm();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
